store_commit_buffer: RTL and testbench

Post-commit store buffer between the reorder buffer's memory-write port and the data cache's write port. It accepts stores the reorder buffer has retired (`we_mem`/`ws_mem`/`wd_mem`) and queues them in FIFO order. It drains them one at a time into the data cache, retrying after a fixed refill delay on a write miss. A combinational lookup port lets load reservation stations forward the youngest buffered value for an address, so loads never read stale cache data.

---
 rtl/store_commit_buffer_pkg.sv | 13 +
 rtl/sb_fifo_mem.sv | 63 ++++++
 rtl/store_commit_buffer.sv | 119 +++++++++++
 tb/tb_store_commit_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/store_commit_buffer_pkg.sv
// Shared definitions for the post-commit store buffer: default word width and
// drain FSM state encodings.
package store_commit_buffer_pkg;

  localparam int unsigned WORD_SIZE = 32;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_WRITE = 2'd1,
    SB_WAIT  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/sb_fifo_mem.sv
// Circular entry storage for the store buffer: address/data arrays, head/tail
// pointers and occupancy count. Exposes the head entry and the whole array for lookup.
module sb_fifo_mem #(
  parameter int unsigned WORD_SIZE = store_commit_buffer_pkg::WORD_SIZE,
  parameter int unsigned SB_DEPTH  = 4,
  localparam int unsigned PtrW     = $clog2(SB_DEPTH),
  localparam int unsigned CntW     = PtrW + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  logic [WORD_SIZE-1:0]               push_addr,
  input  logic [WORD_SIZE-1:0]               push_data,
  output logic [PtrW-1:0]                    head_ptr,
  output logic [CntW-1:0]                    count,
  output logic [WORD_SIZE-1:0]               head_addr,
  output logic [WORD_SIZE-1:0]               head_data,
  output logic [SB_DEPTH-1:0][WORD_SIZE-1:0] addr_arr,
  output logic [SB_DEPTH-1:0][WORD_SIZE-1:0] data_arr
);

  logic [PtrW-1:0]                    head_q, tail_q;
  logic [CntW-1:0]                    count_q;
  logic [SB_DEPTH-1:0][WORD_SIZE-1:0] addr_q, data_q;
  logic                               push_ok, pop_ok;

  // A push at full is refused even if the head pops in the same cycle.
  assign push_ok = push && (count_q != CntW'(SB_DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) tail_q <= tail_q + PtrW'(1);
      if (pop_ok)  head_q <= head_q + PtrW'(1);
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CntW'(1);
      end else if (!push_ok && pop_ok) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Entry contents are qualified by count, so they need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  assign head_ptr  = head_q;
  assign count     = count_q;
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign addr_arr  = addr_q;
  assign data_arr  = data_q;

endmodule

// File: rtl/store_commit_buffer.sv
// Post-commit store buffer: queues retired stores, drains them in order to the
// data cache with miss retry, and forwards the youngest buffered value to loads.
module store_commit_buffer #(
  parameter int unsigned WORD_SIZE    = store_commit_buffer_pkg::WORD_SIZE,
  parameter int unsigned SB_DEPTH     = 4,
  parameter int unsigned MISS_PENALTY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_mem,
  input  logic [WORD_SIZE-1:0] ws_mem,
  input  logic [WORD_SIZE-1:0] wd_mem,
  output logic                 sb_full,
  output logic                 sb_empty,
  output logic                 cache_write_enable,
  output logic [WORD_SIZE-1:0] cache_ptr_write,
  output logic [WORD_SIZE-1:0] cache_val,
  input  logic                 cache_hit_write,
  input  logic [WORD_SIZE-1:0] lookup_addr,
  output logic                 lookup_hit,
  output logic [WORD_SIZE-1:0] lookup_data
);

  import store_commit_buffer_pkg::*;

  localparam int unsigned PtrW  = $clog2(SB_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WaitW = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;

  sb_state_e                          state_q, state_d;
  logic [WaitW-1:0]                   wait_q, wait_d;
  logic                               push, pop;
  logic [PtrW-1:0]                    head_ptr;
  logic [CntW-1:0]                    count;
  logic [WORD_SIZE-1:0]               head_addr, head_data;
  logic [SB_DEPTH-1:0][WORD_SIZE-1:0] addr_arr, data_arr;
  logic [PtrW-1:0]                    idx;

  assign sb_full  = (count == CntW'(SB_DEPTH));
  assign sb_empty = (count == '0);
  assign push     = we_mem && !sb_full;
  assign pop      = (state_q == SB_WRITE) && cache_hit_write && !sb_empty;

  sb_fifo_mem #(
    .WORD_SIZE (WORD_SIZE),
    .SB_DEPTH  (SB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_addr (ws_mem),
    .push_data (wd_mem),
    .head_ptr  (head_ptr),
    .count     (count),
    .head_addr (head_addr),
    .head_data (head_data),
    .addr_arr  (addr_arr),
    .data_arr  (data_arr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SB_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      SB_IDLE: begin
        if (!sb_empty || push) state_d = SB_WRITE;
      end
      SB_WRITE: begin
        if (cache_hit_write) begin
          // Last entry leaves and nothing refills it.
          if ((count == CntW'(1)) && !push) state_d = SB_IDLE;
        end else begin
          state_d = SB_WAIT;
          wait_d  = WaitW'(MISS_PENALTY - 1);
        end
      end
      SB_WAIT: begin
        if (wait_q == '0) begin
          state_d = SB_WRITE;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_comb begin
    cache_write_enable = (state_q == SB_WRITE);
    cache_ptr_write    = sb_empty ? '0 : head_addr;
    cache_val          = sb_empty ? '0 : head_data;
  end

  // Walk oldest to youngest over registered entries; later matches override.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      idx = head_ptr + PtrW'(i);
      if ((CntW'(i) < count) && (addr_arr[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_arr[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: reset values, drain latency, miss retry,
// full handling, streaming throughput, forwarding priority and reset during WAIT.
module tb_store_commit_buffer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         we_mem;
  logic [W-1:0] ws_mem, wd_mem;
  logic         sb_full, sb_empty;
  logic         cache_write_enable;
  logic [W-1:0] cache_ptr_write, cache_val;
  logic         cache_hit_write;
  logic [W-1:0] lookup_addr;
  logic         lookup_hit;
  logic [W-1:0] lookup_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_commit_buffer #(
    .WORD_SIZE    (W),
    .SB_DEPTH     (4),
    .MISS_PENALTY (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .we_mem             (we_mem),
    .ws_mem             (ws_mem),
    .wd_mem             (wd_mem),
    .sb_full            (sb_full),
    .sb_empty           (sb_empty),
    .cache_write_enable (cache_write_enable),
    .cache_ptr_write    (cache_ptr_write),
    .cache_val          (cache_val),
    .cache_hit_write    (cache_hit_write),
    .lookup_addr        (lookup_addr),
    .lookup_hit         (lookup_hit),
    .lookup_data        (lookup_data)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
    if (we && sb_full) begin
      $display("tb: protocol error flagged - commit of addr %h while sb_full, store dropped", a);
    end
    we_mem = we;
    ws_mem = a;
    wd_mem = d;
  endtask

  initial begin
    reset           = 1'b1;
    we_mem          = 1'b0;
    ws_mem          = '0;
    wd_mem          = '0;
    cache_hit_write = 1'b1;
    lookup_addr     = 32'h10;

    // Reset state
    next_cycle();
    check("rst_empty", sb_empty, 1'b1);
    check("rst_full", sb_full, 1'b0);
    check("rst_en", cache_write_enable, 1'b0);
    check("rst_ptr", cache_ptr_write, 32'h0);
    check("rst_val", cache_val, 32'h0);
    check("rst_lk_hit", lookup_hit, 1'b0);
    check("rst_lk_data", lookup_data, 32'h0);

    // Single store, cache hits
    reset = 1'b0;
    drive(1'b1, 32'h10, 32'hAB);
    next_cycle();
    check("t1_en", cache_write_enable, 1'b1);
    check("t1_ptr", cache_ptr_write, 32'h10);
    check("t1_val", cache_val, 32'hAB);
    check("t1_empty", sb_empty, 1'b0);
    check("t1_lk_popping_hit", lookup_hit, 1'b1);
    check("t1_lk_popping_data", lookup_data, 32'hAB);
    drive(1'b0, '0, '0);
    next_cycle();
    check("t1_empty_after", sb_empty, 1'b1);
    check("t1_en_after", cache_write_enable, 1'b0);

    // Fill with misses, refused 5th push, retry after MISS_PENALTY
    cache_hit_write = 1'b0;
    drive(1'b1, 32'h100, 32'hD0);
    next_cycle();
    check("t2_en_c", cache_write_enable, 1'b1);
    check("t2_ptr_c", cache_ptr_write, 32'h100);
    drive(1'b1, 32'h104, 32'hD1);
    next_cycle();
    check("t2_en_w1", cache_write_enable, 1'b0);
    drive(1'b1, 32'h108, 32'hD2);
    next_cycle();
    check("t2_en_w2", cache_write_enable, 1'b0);
    drive(1'b1, 32'h10C, 32'hD3);
    next_cycle();
    check("t2_en_w3", cache_write_enable, 1'b0);
    check("t2_full", sb_full, 1'b1);
    drive(1'b1, 32'h199, 32'hEE);
    next_cycle();
    check("t2_en_w4", cache_write_enable, 1'b0);
    check("t2_full_kept", sb_full, 1'b1);
    lookup_addr = 32'h199;
    #1;
    check("t2_dropped_lk", lookup_hit, 1'b0);
    drive(1'b0, '0, '0);
    next_cycle();
    check("t2_reissue_en", cache_write_enable, 1'b1);
    check("t2_reissue_ptr", cache_ptr_write, 32'h100);
    check("t2_reissue_val", cache_val, 32'hD0);
    cache_hit_write = 1'b1;
    next_cycle();
    check("t2_full_deassert", sb_full, 1'b0);
    check("t2_ptr1", cache_ptr_write, 32'h104);
    next_cycle();
    check("t2_ptr2", cache_ptr_write, 32'h108);
    next_cycle();
    check("t2_ptr3", cache_ptr_write, 32'h10C);
    check("t2_val3", cache_val, 32'hD3);
    next_cycle();
    check("t2_empty", sb_empty, 1'b1);
    check("t2_en_idle", cache_write_enable, 1'b0);

    // Streaming: push every cycle while every write hits
    drive(1'b1, 32'h200, 32'h50);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      check("t3_en", cache_write_enable, 1'b1);
      check("t3_ptr", cache_ptr_write, 32'h200 + 32'(4 * i));
      check("t3_val", cache_val, 32'h50 + 32'(i));
      check("t3_not_full", sb_full, 1'b0);
      check("t3_not_empty", sb_empty, 1'b0);
      if (i < 4) drive(1'b1, 32'h200 + 32'(4 * (i + 1)), 32'h50 + 32'(i + 1));
      else       drive(1'b0, '0, '0);
    end
    next_cycle();
    check("t3_empty", sb_empty, 1'b1);

    // Forwarding priority with the cache missing
    cache_hit_write = 1'b0;
    drive(1'b1, 32'h20, 32'h1);
    next_cycle();
    drive(1'b1, 32'h24, 32'h2);
    next_cycle();
    drive(1'b1, 32'h20, 32'h3);
    lookup_addr = 32'h20;
    #1;
    check("t4_pushing_invisible", lookup_data, 32'h1);
    next_cycle();
    drive(1'b0, '0, '0);
    #1;
    check("t4_lk20_hit", lookup_hit, 1'b1);
    check("t4_lk20_data", lookup_data, 32'h3);
    lookup_addr = 32'h24;
    #1;
    check("t4_lk24_data", lookup_data, 32'h2);
    lookup_addr = 32'h28;
    #1;
    check("t4_lk28_hit", lookup_hit, 1'b0);
    check("t4_lk28_data", lookup_data, 32'h0);
    lookup_addr = 32'h20;

    // Reset while waiting out a miss with 3 entries buffered
    next_cycle();
    check("t5_in_wait", cache_write_enable, 1'b0);
    check("t5_head", cache_ptr_write, 32'h20);
    reset = 1'b1;
    #1;
    check("t5_rst_empty", sb_empty, 1'b1);
    check("t5_rst_full", sb_full, 1'b0);
    check("t5_rst_en", cache_write_enable, 1'b0);
    check("t5_rst_ptr", cache_ptr_write, 32'h0);
    check("t5_rst_val", cache_val, 32'h0);
    check("t5_rst_lk_hit", lookup_hit, 1'b0);
    check("t5_rst_lk_data", lookup_data, 32'h0);
    next_cycle();
    reset           = 1'b0;
    cache_hit_write = 1'b1;
    drive(1'b1, 32'h40, 32'h55);
    next_cycle();
    check("t5_post_en", cache_write_enable, 1'b1);
    check("t5_post_ptr", cache_ptr_write, 32'h40);
    check("t5_post_val", cache_val, 32'h55);
    drive(1'b0, '0, '0);
    next_cycle();
    check("t5_post_empty", sb_empty, 1'b1);
    check("t5_post_idle", cache_write_enable, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
